// File: rtl/sm_mult_seq_pkg.sv
// Shared definitions for the sequential sign-magnitude / unsigned multiplier.
// Holds the FSM state encodings and the operating-mode codes.
package sm_mult_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_Y = 3'd1,
        ST_MULT   = 3'd2,
        ST_OUT_HI = 3'd3,
        ST_OUT_LO = 3'd4
    } state_t;

    localparam logic MODE_SM  = 1'b0;
    localparam logic MODE_UNS = 1'b1;

endpackage

// File: rtl/sm_mult_seq_dp.sv
// Multiplier datapath: M/A/Q registers, W+1-bit adder, right shifter and
// the packing mux that turns the raw product into HI/LO bus words.
module sm_mult_dp
    import sm_mult_defs::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_x,
    input  logic         load_y,
    input  logic         step,
    input  logic         sel_hi,
    input  logic         mode,
    input  logic [W-1:0] ibus,
    output logic [W-1:0] word
);

    logic [W:0]     a_r;
    logic [W-1:0]   q_r;
    logic [W-1:0]   m_r;
    logic           sgn_r;
    logic [W:0]     sum;
    logic [2*W-1:0] prod;

    // SM operands enter with a zero top bit, so the product ends up one bit
    // left of the 2N-bit result; the HI word therefore skips bit 2W-1.
    function automatic logic [W-1:0] pack_word(input logic m, input logic sgn,
                                               input logic [2*W-1:0] p,
                                               input logic hi);
        logic [W-1:0] w;
        if (!hi)
            w = p[W-1:0];
        else if (m == MODE_UNS)
            w = p[2*W-1:W];
        else
            w = {sgn && (p != '0), p[2*W-2:W]};
        return w;
    endfunction

    always_comb begin
        sum = q_r[0] ? a_r + {1'b0, m_r} : a_r;
    end

    assign prod = {a_r[W-1:0], q_r};
    assign word = pack_word(mode, sgn_r, prod, sel_hi);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            q_r   <= '0;
            m_r   <= '0;
            sgn_r <= 1'b0;
        end else if (load_x) begin
            m_r <= ibus;
        end else if (load_y) begin
            a_r <= '0;
            if (mode == MODE_SM) begin
                m_r[W-1] <= 1'b0;
                sgn_r    <= m_r[W-1] ^ ibus[W-1];
                q_r      <= {1'b0, ibus[W-2:0]};
            end else begin
                sgn_r <= 1'b0;
                q_r   <= ibus;
            end
        end else if (step) begin
            a_r <= {1'b0, sum[W:1]};
            q_r <= {sum[0], q_r[W-1:1]};
        end
    end

endmodule

// File: rtl/sm_mult_seq.sv
// Sequential shift-and-add multiplier top: control FSM, iteration counter and
// registered busy/fin/obus around the sm_mult_dp datapath.
module sm_mult_seq
    import sm_mult_defs::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bgn,
    input  logic         mode,
    input  logic [W-1:0] ibus,
    output logic         busy,
    output logic         fin,
    output logic [W-1:0] obus
);

    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] N_SM  = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] N_UNS = CNT_W'(W);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mode_r;
    logic [CNT_W-1:0] n_iter;
    logic             mult_done;
    logic             load_x;
    logic             load_y;
    logic             step;
    logic             sel_hi;
    logic [W-1:0]     dp_word;

    assign n_iter    = (mode_r == MODE_SM) ? N_SM : N_UNS;
    assign mult_done = (cnt == n_iter);
    assign load_x    = (state == ST_IDLE) && bgn;
    assign load_y    = (state == ST_LOAD_Y);
    assign step      = (state == ST_MULT) && !mult_done;
    assign sel_hi    = (state == ST_MULT);

    sm_mult_dp #(.W(W)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load_x (load_x),
        .load_y (load_y),
        .step   (step),
        .sel_hi (sel_hi),
        .mode   (mode_r),
        .ibus   (ibus),
        .word   (dp_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mode_r <= MODE_SM;
            busy   <= 1'b0;
            fin    <= 1'b0;
            obus   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    fin <= 1'b0;
                    if (bgn) begin
                        mode_r <= mode;
                        busy   <= 1'b1;
                        state  <= ST_LOAD_Y;
                    end
                end
                ST_LOAD_Y: begin
                    cnt   <= '0;
                    state <= ST_MULT;
                end
                // The edge after the last iteration presents HI, with the
                // datapath mux already steered to the HI word.
                ST_MULT: begin
                    if (mult_done) begin
                        fin   <= 1'b1;
                        obus  <= dp_word;
                        state <= ST_OUT_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_OUT_HI: begin
                    obus  <= dp_word;
                    state <= ST_OUT_LO;
                end
                ST_OUT_LO: begin
                    fin   <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_mult_seq.sv
// Scoreboard bench for sm_mult_seq (W=8): directed vectors plus random runs
// checked against an arithmetic reference model.
module tb_sm_mult_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         bgn;
    logic         mode;
    logic [W-1:0] ibus;
    logic         busy;
    logic         fin;
    logic [W-1:0] obus;

    int n_checks;
    int n_fail;
    int edge_cnt;

    logic [W-1:0] exp_hi_q[$];
    logic [W-1:0] exp_lo_q[$];
    int           exp_edge_q[$];

    sm_mult_seq #(.W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bgn  (bgn),
        .mode (mode),
        .ibus (ibus),
        .busy (busy),
        .fin  (fin),
        .obus (obus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: sign-magnitude fractional product in Q(2W-1), or plain integer product.
    function automatic logic [2*W-1:0] model(input logic m, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic [2*W-3:0] mag;
        logic           s;
        if (m) return (2*W)'(x) * (2*W)'(y);
        mag = (2*W-2)'(x[W-2:0]) * (2*W-2)'(y[W-2:0]);
        s   = (x[W-1] ^ y[W-1]) && (mag != 0);
        return {s, mag[2*W-3:W-1], mag[W-2:0], 1'b0};
    endfunction

    // Monitor: pops the scoreboard on each fin rise and checks the two-word frame.
    initial begin
        int           phase;
        logic [W-1:0] cur_lo;
        phase  = 0;
        cur_lo = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0;
            end else if (phase == 0) begin
                if (fin) begin
                    if (exp_hi_q.size() == 0) begin
                        check("unexpected_fin", 1, 0);
                    end else begin
                        check("fin_edge", edge_cnt, exp_edge_q.pop_front());
                        check("obus_hi", int'(obus), int'(exp_hi_q.pop_front()));
                        cur_lo = exp_lo_q.pop_front();
                        phase  = 1;
                    end
                end
            end else if (phase == 1) begin
                check("fin_second", int'(fin), 1);
                check("obus_lo", int'(obus), int'(cur_lo));
                phase = 2;
            end else begin
                check("fin_len", int'(fin), 0);
                check("obus_hold", int'(obus), int'(cur_lo));
                check("busy_done", int'(busy), 0);
                phase = 0;
            end
        end
    end

    // noise: 0 = random bgn/ibus/mode while busy, 1 = bgn held high, 2 = bgn low
    task automatic wait_idle(input int noise);
        int n;
        n = 0;
        while (busy && n < 200) begin
            bgn  = (noise == 1) ? 1'b1 : (noise == 0) ? 1'(($urandom & 1)) : 1'b0;
            ibus = W'($urandom);
            mode = 1'($urandom & 1);
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("timeout_idle", 1, 0);
        bgn = 1'b0;
    endtask

    task automatic run(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] hi, input logic [W-1:0] lo, input int noise);
        bgn  = 1'b1;
        mode = m;
        ibus = x;
        exp_hi_q.push_back(hi);
        exp_lo_q.push_back(lo);
        exp_edge_q.push_back(edge_cnt + 1 + (m ? W : W - 1) + 2);
        @(negedge clk);
        check("busy_rise", int'(busy), 1);
        bgn  = (noise == 1) ? 1'b1 : 1'b0;
        mode = ~m;
        ibus = y;
        @(negedge clk);
        wait_idle(noise);
    endtask

    task automatic run_model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                             input int noise);
        logic [2*W-1:0] p;
        p = model(m, x, y);
        run(m, x, y, p[2*W-1:W], p[W-1:0], noise);
    endtask

    initial begin
        int t0;
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        bgn  = 1'b0;
        mode = 1'b0;
        ibus = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_fin", int'(fin), 0);
        check("rst_obus", int'(obus), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, 8'h97, 8'h83, 8'h00, 8'h8A, 2);
        run(1'b0, 8'hFF, 8'h7F, 8'hFE, 8'h02, 2);
        run(1'b0, 8'h80, 8'h05, 8'h00, 8'h00, 2);
        run(1'b1, 8'd200, 8'd200, 8'h9C, 8'h40, 2);
        run(1'b1, 8'hFF, 8'hFF, 8'hFE, 8'h01, 2);
        run(1'b0, 8'h97, 8'h83, 8'h00, 8'h8A, 2);

        // Abort a run mid-MULT with an asynchronous reset.
        bgn  = 1'b1;
        mode = 1'b0;
        ibus = 8'h97;
        t0   = edge_cnt + 1;
        @(negedge clk);
        bgn  = 1'b0;
        ibus = 8'h83;
        while (edge_cnt < t0 + 5) @(posedge clk);
        #1;
        check("busy_pre_rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_fin", int'(fin), 0);
        check("midrst_obus", int'(obus), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(1'b0, 8'h97, 8'h83, 8'h00, 8'h8A, 2);

        // bgn held high for the whole run: one result only.
        run(1'b1, 8'd13, 8'd11, 8'h00, 8'd143, 1);
        repeat (3) @(negedge clk);
        check("hold_no_restart", int'(busy), 0);

        // Back-to-back and random runs, with noise on the inputs while busy.
        run(1'b1, 8'h12, 8'h34, 8'h03, 8'hA8, 2);
        for (int i = 0; i < 40; i++) begin
            run_model(1'($urandom & 1), W'($urandom), W'($urandom), (i % 3 == 0) ? 0 : 2);
            if ((i % 4) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        run_model(1'b0, 8'h00, 8'h00, 0);
        run_model(1'b1, 8'h00, 8'hFF, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_hi_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
